// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg
// Shared constants and helpers for the single-clock FIFO.
//   SYNC_FIFO_WIDTH_DEF : default data word width
//   SYNC_FIFO_DEPTH_DEF : default number of entries
//   count_next()        : occupancy update from the two fire strobes
package sync_fifo_pkg;

  localparam int SYNC_FIFO_WIDTH_DEF = 32;
  localparam int SYNC_FIFO_DEPTH_DEF = 16;

  // Occupancy after one cycle. Worked at 32 bits so callers of any
  // count width can share it; callers truncate to their own width.
  function automatic logic [31:0] count_next(input logic [31:0] cnt,
                                             input logic        wr_fire,
                                             input logic        rd_fire);
    return cnt + {31'b0, wr_fire} - {31'b0, rd_fire};
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem
// Storage array for sync_fifo: one write port, one registered read port.
// Ports:
//   clk      : clock, all logic on posedge
//   srst     : synchronous active-high reset (read register only)
//   wr_en    : write strobe (already qualified by the caller)
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : read strobe (already qualified by the caller)
//   rd_addr  : read address
//   rd_data  : registered read data, holds when no read
//   rd_valid : one-cycle pulse, rd_data updated this cycle
module sync_fifo_mem #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_valid
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_valid;

  // Array contents are deliberately not reset so the storage maps to RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) begin
        r_rd_data <= r_mem[rd_addr];
      end
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock FIFO with occupancy count, almost-full/almost-empty flags
// and registered read data. No fall-through: a write is blocked while
// full and a read is blocked while empty, regardless of the other side.
// Optional feature macro: SYNC_FIFO_ERR_EN adds sticky overflow and
// underflow flags (ports absent when the macro is undefined).
// Ports:
//   clk          : clock, all logic on posedge
//   async_rst    : synchronous active-high reset (name kept for
//                  compatibility with the dual-clock FIFO)
//   wr_en/wr_data: write request and data
//   full         : no free entries
//   almost_full  : count >= AF_THRESH
//   rd_en        : read request
//   rd_data      : registered read data
//   rd_valid     : rd_data updated this cycle
//   empty        : no stored entries
//   almost_empty : count <= AE_THRESH
//   count        : occupancy 0..DEPTH
//   overflow     : sticky, write attempted while full (SYNC_FIFO_ERR_EN)
//   underflow    : sticky, read attempted while empty (SYNC_FIFO_ERR_EN)
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH      = SYNC_FIFO_WIDTH_DEF,
  parameter int DEPTH      = SYNC_FIFO_DEPTH_DEF,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  async_rst,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
`ifdef SYNC_FIFO_ERR_EN
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic [ADDR_WIDTH:0]   count
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [CW-1:0] r_wptr;
  logic [CW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_full;
  logic          r_empty;
  logic          r_almost_full;
  logic          r_almost_empty;

  logic          w_wr_fire;
  logic          w_rd_fire;
  logic [CW-1:0] w_count_next;

  // Fire strobes use only registered flags, so there is no path from
  // rd_en to the write side or from wr_en to the read side.
  assign w_wr_fire    = wr_en && !r_full;
  assign w_rd_fire    = rd_en && !r_empty;
  assign w_count_next = CW'(count_next(32'(r_count), w_wr_fire, w_rd_fire));

  always_ff @(posedge clk) begin
    if (async_rst) begin
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_count        <= '0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      // Pointers carry one extra bit and wrap modulo 2*DEPTH.
      r_wptr         <= r_wptr + CW'(w_wr_fire);
      r_rptr         <= r_rptr + CW'(w_rd_fire);
      r_count        <= w_count_next;
      // Flags come from the next count so they always agree with count.
      r_full         <= (w_count_next == DEPTH_C);
      r_empty        <= (w_count_next == '0);
      r_almost_full  <= (w_count_next >= AF_C);
      r_almost_empty <= (w_count_next <= AE_C);
    end
  end

`ifdef SYNC_FIFO_ERR_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk) begin
    if (async_rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en && r_full) begin
        r_overflow <= 1'b1;
      end
      if (rd_en && r_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

  sync_fifo_mem #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .srst    (async_rst),
    .wr_en   (w_wr_fire),
    .wr_addr (r_wptr[ADDR_WIDTH-1:0]),
    .wr_data (wr_data),
    .rd_en   (w_rd_fire),
    .rd_addr (r_rptr[ADDR_WIDTH-1:0]),
    .rd_data (rd_data),
    .rd_valid(rd_valid)
  );

  // The count register and the pointer difference must never disagree.
  ptr_count_a: assert property (@(posedge clk) disable iff (async_rst)
    r_count == CW'(r_wptr - r_rptr));

  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
  assign count        = r_count;

endmodule
